bcd_seq_ctrl: RTL and testbench

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

---
 rtl/bcd_seq_ctrl_pkg.sv | 14 +
 rtl/bcd_digit.sv | 46 ++++
 rtl/bcd_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_bcd_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seq_ctrl_pkg.sv
// Shared types and constants for the BCD sequence controller and its decade cells.
package bcd_seq_ctrl_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: registered value with clear/load, plus a ripple carry (or borrow) to the next decade.
module bcd_digit
   import bcd_seq_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               r,
   input  logic               clr,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_val,
   input  logic               en,
   input  logic               cin,
   input  logic               dn,
   output logic [DIGIT_W-1:0] val,
   output logic [DIGIT_W-1:0] nxt,
   output logic               cout
);

   logic at_edge;

   // nxt is exposed so the parent can compare against the value the step will produce
   always_comb begin
      at_edge = dn ? (val == '0) : (val == BCD_MAX);
      cout    = cin && at_edge;
      nxt     = val;
      if (cin) begin
         if (dn) begin
            nxt = at_edge ? BCD_MAX : val - 1'b1;
         end else begin
            nxt = at_edge ? '0 : val + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r) begin
         val <= '0;
      end else if (clr) begin
         val <= '0;
      end else if (load) begin
         val <= load_val;
      end else if (en) begin
         val <= nxt;
      end
   end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Prescaled cascaded BCD counter with start/stop/clear sequencing and terminal-value detect.
// Optional down-count mode is built in when BCD_SEQ_CTRL_DOWN_EN is defined.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | count and prescaler zero, waiting for start
//   RUN   | prescaler advancing, count steps on each tick
//   HOLD  | paused by stop; count and prescaler frozen
//   DONE  | terminal value reached; count held until start or clear
module bcd_seq_ctrl
   import bcd_seq_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 10
)
(
   input  logic                          clk,
   input  logic                          r,
   input  logic                          start,
   input  logic                          stop,
   input  logic                          clear,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] limit,
`ifdef BCD_SEQ_CTRL_DOWN_EN
   input  logic                          down,
`endif
   output logic [DIGIT_W*NUM_DIGITS-1:0] count,
   output logic                          busy,
   output logic                          done,
   output logic                          wrap
);

   localparam int CW    = DIGIT_W * NUM_DIGITS;
   localparam int PSC_W = 16;
   localparam logic [PSC_W-1:0] PSC_TC = PSC_W'(PRESCALE - 1);

   state_t           state;
   state_t           state_nxt;
   logic [PSC_W-1:0] psc;
   logic [CW-1:0]    lim_q;
   logic [CW-1:0]    cnt_nxt;
   logic [CW-1:0]    load_val;
   logic [CW-1:0]    target;
   logic [NUM_DIGITS:0] carry;
   logic             down_in;
   logic             down_q;
   logic             at_tc;
   logic             match;
   logic             psc_clr;
   logic             psc_inc;
   logic             cnt_clr;
   logic             cnt_load;
   logic             cnt_step;
   logic             lim_cap;
   logic             done_set;
   logic             wrap_set;

`ifdef BCD_SEQ_CTRL_DOWN_EN
   assign down_in = down;

   always_ff @(posedge clk) begin
      if (r) begin
         down_q <= 1'b0;
      end else if (lim_cap) begin
         down_q <= down;
      end
   end
`else
   assign down_in = 1'b0;
   assign down_q  = 1'b0;
`endif

   assign load_val = down_in ? limit : '0;
   assign target   = down_q ? '0 : lim_q;
   assign match    = (cnt_nxt == target);
   assign at_tc    = (psc == PSC_TC);
   assign carry[0] = 1'b1;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clk      (clk),
         .r        (r),
         .clr      (cnt_clr),
         .load     (cnt_load),
         .load_val (load_val[g*DIGIT_W +: DIGIT_W]),
         .en       (cnt_step),
         .cin      (carry[g]),
         .dn       (down_q),
         .val      (count[g*DIGIT_W +: DIGIT_W]),
         .nxt      (cnt_nxt[g*DIGIT_W +: DIGIT_W]),
         .cout     (carry[g+1])
      );
   end

   always_ff @(posedge clk) begin
      if (r) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      psc_clr   = 1'b0;
      psc_inc   = 1'b0;
      cnt_clr   = 1'b0;
      cnt_load  = 1'b0;
      cnt_step  = 1'b0;
      lim_cap   = 1'b0;
      done_set  = 1'b0;
      wrap_set  = 1'b0;
      if (clear) begin
         state_nxt = IDLE;
         psc_clr   = 1'b1;
         cnt_clr   = 1'b1;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start && !stop) begin
                  state_nxt = RUN;
                  psc_clr   = 1'b1;
                  cnt_load  = 1'b1;
                  lim_cap   = 1'b1;
                  // counting down from zero has nothing to do
                  if (down_in && (limit == '0)) begin
                     state_nxt = DONE;
                     done_set  = 1'b1;
                  end
               end
            end
            RUN: begin
               if (stop) begin
                  state_nxt = HOLD;
               end else if (at_tc) begin
                  psc_clr  = 1'b1;
                  cnt_step = 1'b1;
                  wrap_set = carry[NUM_DIGITS];
                  if (match) begin
                     state_nxt = DONE;
                     done_set  = 1'b1;
                  end
               end else begin
                  psc_inc = 1'b1;
               end
            end
            HOLD: begin
               if (start && !stop) begin
                  state_nxt = RUN;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r) begin
         psc <= '0;
      end else if (psc_clr) begin
         psc <= '0;
      end else if (psc_inc) begin
         psc <= psc + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (r) begin
         lim_q <= '0;
      end else if (lim_cap) begin
         lim_q <= limit;
      end
   end

   always_ff @(posedge clk) begin
      if (r) begin
         done <= 1'b0;
         wrap <= 1'b0;
      end else begin
         done <= done_set;
         wrap <= wrap_set;
      end
   end

   assign busy = (state == RUN) || (state == HOLD);

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Scoreboard bench for bcd_seq_ctrl: two instances (PRESCALE 1 and 3), expected count events queued per instance.
module tb_bcd_seq_ctrl;

   typedef struct {
      int          cyc;
      logic [15:0] cnt;
      logic        dn;
      logic        wr;
   } ev_t;

   logic clk = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        r_a, start_a, stop_a, clear_a, busy_a, done_a, wrap_a;
   logic [15:0] limit_a, count_a;
   logic        r_b, start_b, stop_b, clear_b, busy_b, done_b, wrap_b;
   logic [15:0] limit_b, count_b;
`ifdef BCD_SEQ_CTRL_DOWN_EN
   logic        down_a, down_b;
`endif

   bcd_seq_ctrl #(.NUM_DIGITS(4), .PRESCALE(1)) dut_a (
      .clk(clk), .r(r_a), .start(start_a), .stop(stop_a), .clear(clear_a), .limit(limit_a),
`ifdef BCD_SEQ_CTRL_DOWN_EN
      .down(down_a),
`endif
      .count(count_a), .busy(busy_a), .done(done_a), .wrap(wrap_a)
   );

   bcd_seq_ctrl #(.NUM_DIGITS(4), .PRESCALE(3)) dut_b (
      .clk(clk), .r(r_b), .start(start_b), .stop(stop_b), .clear(clear_b), .limit(limit_b),
`ifdef BCD_SEQ_CTRL_DOWN_EN
      .down(down_b),
`endif
      .count(count_b), .busy(busy_b), .done(done_b), .wrap(wrap_b)
   );

   int  checks   = 0;
   int  failures = 0;
   ev_t qa[$];
   ev_t qb[$];
   ev_t ea, eb;
   logic [15:0] prev_a = '0;
   logic [15:0] prev_b = '0;
   logic mon_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] res;
      int t;
      t = v;
      for (int i = 0; i < 4; i++) begin
         res[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return res;
   endfunction

   function automatic void push_a(input int c, input logic [15:0] v, input logic d, input logic w);
      qa.push_back('{c, v, d, w});
   endfunction

   function automatic void push_b(input int c, input logic [15:0] v, input logic d, input logic w);
      qb.push_back('{c, v, d, w});
   endfunction

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Any count change or pulse is a DUT event that must match the next queued expectation.
   always @(negedge clk) begin
      if (mon_en && (count_a != prev_a || done_a || wrap_a)) begin
         if (qa.size() == 0) begin
            chk("a_unexpected_event", {count_a, done_a, wrap_a}, {prev_a, 2'b00});
         end else begin
            ea = qa.pop_front();
            chk("a_ev_cyc", cyc, ea.cyc);
            chk("a_ev_count", count_a, ea.cnt);
            chk("a_ev_done", done_a, ea.dn);
            chk("a_ev_wrap", wrap_a, ea.wr);
         end
      end
      prev_a = count_a;
   end

   always @(negedge clk) begin
      if (mon_en && (count_b != prev_b || done_b || wrap_b)) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_event", {count_b, done_b, wrap_b}, {prev_b, 2'b00});
         end else begin
            eb = qb.pop_front();
            chk("b_ev_cyc", cyc, eb.cyc);
            chk("b_ev_count", count_b, eb.cnt);
            chk("b_ev_done", done_b, eb.dn);
            chk("b_ev_wrap", wrap_b, eb.wr);
         end
      end
      prev_b = count_b;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      r_a = 1'b1; start_a = 1'b0; stop_a = 1'b0; clear_a = 1'b0; limit_a = '0;
      r_b = 1'b1; start_b = 1'b0; stop_b = 1'b0; clear_b = 1'b0; limit_b = '0;
`ifdef BCD_SEQ_CTRL_DOWN_EN
      down_a = 1'b0; down_b = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_count_a", count_a, 16'h0000);
      chk("rst_busy_a", busy_a, 1'b0);
      chk("rst_done_a", done_a, 1'b0);
      chk("rst_wrap_a", wrap_a, 1'b0);
      chk("rst_count_b", count_b, 16'h0000);
      chk("rst_busy_b", busy_b, 1'b0);
      r_a = 1'b0; r_b = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // limit 0x0012 at one tick per cycle
      limit_a = 16'h0012;
      start_a = 1'b1; s = cyc + 1;
      for (int k = 1; k <= 12; k++) push_a(s + k, to_bcd(k), k == 12, 1'b0);
      @(negedge clk); start_a = 1'b0;
      wait_cyc(s + 16);
      chk("t1_busy", busy_a, 1'b0);
      chk("t1_hold", count_a, 16'h0012);
      chk("t1_sb", qa.size(), 0);

      // restart from DONE reloads; limit change after capture is ignored
      limit_a = 16'h0003;
      start_a = 1'b1; s = cyc + 1;
      push_a(s, 16'h0000, 1'b0, 1'b0);
      for (int k = 1; k <= 3; k++) push_a(s + k, to_bcd(k), k == 3, 1'b0);
      @(negedge clk); start_a = 1'b0; limit_a = 16'h0001;
      wait_cyc(s + 6);
      chk("t1b_busy", busy_a, 1'b0);
      chk("t1b_count", count_a, 16'h0003);
      chk("t1b_sb", qa.size(), 0);

      // invalid limit never matches; one wrap in 10000 ticks
      limit_a = 16'hFFFF;
      start_a = 1'b1; s = cyc + 1;
      push_a(s, 16'h0000, 1'b0, 1'b0);
      for (int k = 1; k <= 10000; k++) push_a(s + k, to_bcd(k % 10000), 1'b0, k == 10000);
      @(negedge clk); start_a = 1'b0;
      wait_cyc(s + 10000);
      chk("t2_busy_run", busy_a, 1'b1);
      clear_a = 1'b1;
      @(negedge clk); clear_a = 1'b0;
      chk("t2_clr_busy", busy_a, 1'b0);
      chk("t2_sb", qa.size(), 0);

      // limit 0: done and wrap together after a full wrap
      limit_a = 16'h0000;
      start_a = 1'b1; s = cyc + 1;
      for (int k = 1; k <= 10000; k++) push_a(s + k, to_bcd(k % 10000), k == 10000, k == 10000);
      @(negedge clk); start_a = 1'b0;
      wait_cyc(s + 10002);
      chk("t3_busy", busy_a, 1'b0);
      chk("t3_count", count_a, 16'h0000);
      chk("t3_sb", qa.size(), 0);

      // clear wins over start in RUN
      limit_a = 16'h0050;
      start_a = 1'b1; s = cyc + 1;
      for (int k = 1; k <= 5; k++) push_a(s + k, to_bcd(k), 1'b0, 1'b0);
      @(negedge clk); start_a = 1'b0;
      wait_cyc(s + 5);
      clear_a = 1'b1; start_a = 1'b1;
      push_a(s + 6, 16'h0000, 1'b0, 1'b0);
      @(negedge clk); clear_a = 1'b0; start_a = 1'b0;
      chk("t4_clr_busy", busy_a, 1'b0);
      chk("t4_clr_done", done_a, 1'b0);

      // reset mid-run aborts without pulses
      start_a = 1'b1; s = cyc + 1;
      for (int k = 1; k <= 3; k++) push_a(s + k, to_bcd(k), 1'b0, 1'b0);
      @(negedge clk); start_a = 1'b0;
      wait_cyc(s + 3);
      r_a = 1'b1;
      push_a(s + 4, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      chk("t4_rst_count", count_a, 16'h0000);
      chk("t4_rst_busy", busy_a, 1'b0);
      chk("t4_rst_done", done_a, 1'b0);
      chk("t4_rst_wrap", wrap_a, 1'b0);
      r_a = 1'b0;
      @(negedge clk);
      chk("t4_sb", qa.size(), 0);

`ifdef BCD_SEQ_CTRL_DOWN_EN
      down_a = 1'b1;
      limit_a = 16'h0010;
      start_a = 1'b1; s = cyc + 1;
      push_a(s, 16'h0010, 1'b0, 1'b0);
      for (int k = 1; k <= 10; k++) push_a(s + k, to_bcd(10 - k), k == 10, 1'b0);
      @(negedge clk); start_a = 1'b0;
      wait_cyc(s + 12);
      chk("dn_busy", busy_a, 1'b0);
      limit_a = 16'h0000;
      start_a = 1'b1; s = cyc + 1;
      push_a(s, 16'h0000, 1'b1, 1'b0);
      @(negedge clk); start_a = 1'b0;
      wait_cyc(s + 2);
      chk("dn_zero_busy", busy_a, 1'b0);
      chk("dn_sb", qa.size(), 0);
      down_a = 1'b0;
`endif

      // PRESCALE=3: 0099->0100 exactly 300 cycles after start
      limit_b = 16'h0100;
      start_b = 1'b1; s = cyc + 1;
      for (int k = 1; k <= 100; k++) push_b(s + 3 * k, to_bcd(k), k == 100, 1'b0);
      @(negedge clk); start_b = 1'b0;
      wait_cyc(s + 302);
      chk("t5_busy", busy_b, 1'b0);
      chk("t5_count", count_b, 16'h0100);
      chk("t5_sb", qb.size(), 0);

      // pause with prescaler at 1; five stop cycles plus the resume cycle delay every later tick by 6
      limit_b = 16'h0020;
      start_b = 1'b1; s = cyc + 1;
      push_b(s, 16'h0000, 1'b0, 1'b0);
      push_b(s + 3, 16'h0001, 1'b0, 1'b0);
      for (int k = 2; k <= 20; k++) push_b(s + 3 * k + 6, to_bcd(k), k == 20, 1'b0);
      @(negedge clk); start_b = 1'b0;
      wait_cyc(s + 4);
      stop_b = 1'b1;
      repeat (5) @(negedge clk);
      chk("t6_hold_busy", busy_b, 1'b1);
      chk("t6_frozen", count_b, 16'h0001);
      stop_b = 1'b0; start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      wait_cyc(s + 3 * 20 + 8);
      chk("t6_busy", busy_b, 1'b0);
      chk("t6_count", count_b, 16'h0020);
      chk("t6_sb", qb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
